// File: rtl/ls_pkg.sv
// Shared definitions for the load/store execution unit: op encodings,
// op decode helpers, idle values of the write-back bus and the FSM states.
package ls_pkg;

    localparam int LS_TAG_W = 5;
    localparam int LS_OP_W  = 6;

    localparam logic [LS_OP_W-1:0] OP_LB  = 6'd1;
    localparam logic [LS_OP_W-1:0] OP_LH  = 6'd2;
    localparam logic [LS_OP_W-1:0] OP_LW  = 6'd3;
    localparam logic [LS_OP_W-1:0] OP_LBU = 6'd4;
    localparam logic [LS_OP_W-1:0] OP_LHU = 6'd5;
    localparam logic [LS_OP_W-1:0] OP_SB  = 6'd6;
    localparam logic [LS_OP_W-1:0] OP_SH  = 6'd7;
    localparam logic [LS_OP_W-1:0] OP_SW  = 6'd8;

    // Broadcast bus values when no load result is being published.
    localparam logic [LS_TAG_W-1:0] TAG_FREE  = 5'd0;
    localparam logic [31:0]         DATA_FREE = 32'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of bytes moved by an op; 0 marks an unknown op.
    function automatic logic [2:0] op_len(input logic [LS_OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
            OP_LW, OP_SW:         op_len = 3'd4;
            default:              op_len = 3'd0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [LS_OP_W-1:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
            default:             op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_signed(input logic [LS_OP_W-1:0] op);
        case (op)
            OP_LB, OP_LH: op_is_signed = 1'b1;
            default:      op_is_signed = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_valid(input logic [LS_OP_W-1:0] op);
        op_is_valid = (op_len(op) != 3'd0);
    endfunction

    // Little-endian byte extraction from a word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    // Little-endian byte insertion into a word.
    function automatic logic [31:0] byte_ins(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ls_exec_unit_if.sv
// Bundle of the LS buffer handshake, the LS write-back bus and the byte-wide
// memory-controller port. The unit is the slave side of this bundle.
interface ls_exec_unit_if #(
    parameter int TAG_W = 5,
    parameter int OP_W  = 6
);
    // issue side (from LS buffer)
    logic             LSworkEn;
    logic [31:0]      operandO;
    logic [31:0]      operandT;
    logic [31:0]      imm;
    logic [TAG_W-1:0] wrtTag;
    logic [OP_W-1:0]  opCode;
    logic             LSreadEn;
    logic             LSdone;
    // load write-back broadcast
    logic             enLSwrt;
    logic [TAG_W-1:0] LStag;
    logic [31:0]      LSdata;
    // memory-controller byte port
    logic             memReq;
    logic             memWe;
    logic [31:0]      memAddr;
    logic [7:0]       memWdata;
    logic             memGrant;
    logic [7:0]       memRdata;

    modport master (
        output LSworkEn, operandO, operandT, imm, wrtTag, opCode, memGrant, memRdata,
        input  LSreadEn, LSdone, enLSwrt, LStag, LSdata, memReq, memWe, memAddr, memWdata
    );

    modport slave (
        input  LSworkEn, operandO, operandT, imm, wrtTag, opCode, memGrant, memRdata,
        output LSreadEn, LSdone, enLSwrt, LStag, LSdata, memReq, memWe, memAddr, memWdata
    );
endinterface

// File: rtl/ls_extend.sv
// Sign/zero extension of a raw little-endian load value according to the op.
// Kept separate so a future cache hit path can share it.
module ls_extend
    import ls_pkg::*;
(
    input  logic [31:0]         raw_i,
    input  logic [LS_OP_W-1:0]  op_i,
    output logic [31:0]         result_o
);

    // Extend the low byte/half-word; word loads and anything else pass through.
    always_comb begin
        result_o = raw_i;
        case (op_i)
            OP_LB:   result_o = {{24{raw_i[7]}}, raw_i[7:0]};
            OP_LBU:  result_o = {24'd0, raw_i[7:0]};
            OP_LH:   result_o = {{16{raw_i[15]}}, raw_i[15:0]};
            OP_LHU:  result_o = {16'd0, raw_i[15:0]};
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/ls_exec_unit.sv
// Load/store execution stage: takes one op from the LS buffer, forms
// base+imm, moves 1/2/4 bytes serially over the memory port, then pulses
// LSdone (and, for loads, broadcasts the extended result) for one cycle.
module ls_exec_unit
    import ls_pkg::*;
#(
    parameter int TAG_W = LS_TAG_W,
    parameter int OP_W  = LS_OP_W
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy,
    ls_exec_unit_if.slave  bus
);

    state_e           state_q, state_d;
    logic [2:0]       req_cnt_q, req_cnt_d;
    logic [2:0]       rsp_cnt_q, rsp_cnt_d;
    logic [2:0]       len_q, len_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic             rd_pend_q, rd_pend_d;

    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;
    logic             ls_done_q, ls_done_d;
    logic             en_ls_wrt_q, en_ls_wrt_d;
    logic [TAG_W-1:0] ls_tag_q, ls_tag_d;
    logic [31:0]      ls_data_q, ls_data_d;

    logic             grant_s;
    logic             store_s;
    logic [2:0]       last_idx_s;
    logic [31:0]      ext_s;

    assign grant_s    = bus.memGrant & mem_req_q;
    assign store_s    = op_is_store(op_q);
    assign last_idx_s = len_q - 3'd1;

    // Block a second issue while busy and in the very cycle an issue is offered.
    assign bus.LSreadEn = (state_q == IDLE) & ~bus.LSworkEn;

    ls_extend u_extend (
        .raw_i    (ld_data_q),
        .op_i     (op_q),
        .result_o (ext_s)
    );

    // Next state, byte counters, load assembly and the next output-register values.
    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        data_d    = data_q;
        op_d      = op_q;
        tag_d     = tag_q;
        ld_data_d = ld_data_q;
        rd_pend_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.LSworkEn) begin
                    addr_d    = bus.operandO + bus.imm;
                    data_d    = bus.operandT;
                    op_d      = bus.opCode;
                    tag_d     = bus.wrtTag;
                    len_d     = op_len(bus.opCode);
                    req_cnt_d = 3'd0;
                    rsp_cnt_d = 3'd0;
                    ld_data_d = 32'd0;
                    if (op_is_valid(bus.opCode)) begin
                        state_d = XFER;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (grant_s) begin
                    req_cnt_d = req_cnt_q + 3'd1;
                end else begin
                    req_cnt_d = req_cnt_q;
                end
                // A granted read returns its byte on the following cycle.
                rd_pend_d = grant_s & ~store_s;
                if (rd_pend_q) begin
                    ld_data_d = byte_ins(ld_data_q, rsp_cnt_q[1:0], bus.memRdata);
                    rsp_cnt_d = rsp_cnt_q + 3'd1;
                end else begin
                    rsp_cnt_d = rsp_cnt_q;
                end
                if (store_s && grant_s && (req_cnt_q == last_idx_s)) begin
                    state_d = DONE;
                end else if (!store_s && rd_pend_q && (rsp_cnt_q == last_idx_s)) begin
                    state_d = DONE;
                end else begin
                    state_d = XFER;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Memory request follows the next counter value so it drops right after the last grant.
        mem_req_d = (state_d == XFER) && (req_cnt_d < len_d);
        if (mem_req_d) begin
            mem_we_d    = op_is_store(op_d);
            mem_addr_d  = addr_d + {29'd0, req_cnt_d};
            mem_wdata_d = op_is_store(op_d) ? byte_sel(data_d, req_cnt_d[1:0]) : 8'd0;
        end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = 32'd0;
            mem_wdata_d = 8'd0;
        end

        // Retirement outputs are published on the cycle after DONE.
        if (state_q == DONE) begin
            ls_done_d   = 1'b1;
            en_ls_wrt_d = op_is_valid(op_q) & ~op_is_store(op_q);
        end else begin
            ls_done_d   = 1'b0;
            en_ls_wrt_d = 1'b0;
        end
        if (en_ls_wrt_d) begin
            ls_tag_d  = tag_q;
            ls_data_d = ext_s;
        end else begin
            ls_tag_d  = TAG_FREE;
            ls_data_d = DATA_FREE;
        end
    end

    // State, counters and output registers; everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_cnt_q   <= 3'd0;
            rsp_cnt_q   <= 3'd0;
            len_q       <= 3'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            op_q        <= '0;
            tag_q       <= '0;
            ld_data_q   <= 32'd0;
            rd_pend_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 8'd0;
            ls_done_q   <= 1'b0;
            en_ls_wrt_q <= 1'b0;
            ls_tag_q    <= TAG_FREE;
            ls_data_q   <= DATA_FREE;
        end else if (rdy) begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            ld_data_q   <= ld_data_d;
            rd_pend_q   <= rd_pend_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ls_done_q   <= ls_done_d;
            en_ls_wrt_q <= en_ls_wrt_d;
            ls_tag_q    <= ls_tag_d;
            ls_data_q   <= ls_data_d;
        end
    end

    assign bus.memReq   = mem_req_q;
    assign bus.memWe    = mem_we_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memWdata = mem_wdata_q;
    assign bus.LSdone   = ls_done_q;
    assign bus.enLSwrt  = en_ls_wrt_q;
    assign bus.LStag    = ls_tag_q;
    assign bus.LSdata   = ls_data_q;

endmodule
